// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline: the ALU operation encodings, the
// register-number and data widths, the layout of the ID/EX pipeline register,
// and a saturating 16-bit increment used by the bubble counter.
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int unsigned DW = 32;  // datapath width
   localparam int unsigned RW = 5;   // register-number width

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_AND = 4'b0001,
      ALU_XOR = 4'b0010,
      ALU_SLL = 4'b0011,
      ALU_SUB = 4'b0100,
      ALU_OR  = 4'b0101,
      ALU_LUI = 4'b0110,
      ALU_SRL = 4'b0111,
      ALU_SRA = 4'b1111
   } alu_op_e;

   // Everything the EX stage holds for one instruction.  An all-zero value
   // is the bubble.
   typedef struct packed {
      logic          valid;
      logic          wreg;
      logic          m2reg;
      logic          wmem;
      logic          jal;
      logic          shift;
      logic          aluimm;
      logic [3:0]    aluc;
      logic [RW-1:0] rn;
      logic [RW-1:0] sa;
      logic [DW-1:0] pc4;
      logic [DW-1:0] imm;
      logic [DW-1:0] qa;   // forwarded rs operand
      logic [DW-1:0] qb;   // forwarded rt operand (also store data)
   } ex_regs_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Operand forwarding select for one source register.
// Priority: result of the ALU instruction in EX, then the final result of
// the instruction in MEM, else the register-file read data.  Register 0 is
// never forwarded.  A load in EX is not forwarded (its data is not yet known);
// the decode stage stalls for it instead.
//   src_i        source register number
//   rf_data_i    register-file read data for src_i
//   ex_*_i       EX-stage valid / wreg / m2reg / destination / ALU result
//   mem_*_i      MEM-stage wreg / destination / final result
//   data_o       selected operand
// ---------------------------------------------------------------------------
module fwd_mux
   import pipe_pkg::*;
(
   input  logic [RW-1:0] src_i,
   input  logic [DW-1:0] rf_data_i,
   input  logic          ex_valid_i,
   input  logic          ex_wreg_i,
   input  logic          ex_m2reg_i,
   input  logic [RW-1:0] ex_rn_i,
   input  logic [DW-1:0] ex_result_i,
   input  logic          mem_wreg_i,
   input  logic [RW-1:0] mem_rn_i,
   input  logic [DW-1:0] mem_result_i,
   output logic [DW-1:0] data_o
);

   logic src_nz;
   logic ex_hit;
   logic mem_hit;

   assign src_nz  = (src_i != '0);
   assign ex_hit  = ex_valid_i & ex_wreg_i & ~ex_m2reg_i & (ex_rn_i == src_i) & src_nz;
   assign mem_hit = mem_wreg_i & (mem_rn_i == src_i) & src_nz;

   always_comb begin
      data_o = rf_data_i;
      if (ex_hit)       data_o = ex_result_i;
      else if (mem_hit) data_o = mem_result_i;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection and bubble insertion.
//   clock, resetn              clock, asynchronous active-low reset
//   d_*                        decoded instruction from the ID stage
//   e_r                        ALU result of the instruction now in EX
//   m_rn, m_wreg, m_data       MEM-stage destination, write enable, result
//   flush                      kill the instruction in decode
//   stall                      hold PC and IF/ID (combinational)
//   alu_a, alu_b, aluc         ALU operands/op, combinational from EX regs
//   e_valid ... e_db           EX-stage controls, PC+4 and store data
//   bubble_cnt                 saturating count of hazard/flush bubbles
// Handshake: no valid/ready; d_valid qualifies the decode slot, and the
// producer must hold the decode slot unchanged while stall is high.
// ---------------------------------------------------------------------------
module id_ex_stage
   import pipe_pkg::*;
(
   input  logic          clock,
   input  logic          resetn,
   input  logic          d_valid,
   input  logic [4:0]    d_rs,
   input  logic [4:0]    d_rt,
   input  logic          d_use_rs,
   input  logic          d_use_rt,
   input  logic [31:0]   d_qa,
   input  logic [31:0]   d_qb,
   input  logic [31:0]   d_imm,
   input  logic [4:0]    d_sa,
   input  logic [31:0]   d_pc4,
   input  logic [4:0]    d_rn,
   input  logic          d_wreg,
   input  logic          d_m2reg,
   input  logic          d_wmem,
   input  logic          d_aluimm,
   input  logic          d_shift,
   input  logic          d_jal,
   input  logic [3:0]    d_aluc,
   input  logic [31:0]   e_r,
   input  logic [4:0]    m_rn,
   input  logic          m_wreg,
   input  logic [31:0]   m_data,
   input  logic          flush,
   output logic          stall,
   output logic [31:0]   alu_a,
   output logic [31:0]   alu_b,
   output logic [3:0]    aluc,
   output logic          e_valid,
   output logic          e_wreg,
   output logic          e_m2reg,
   output logic          e_wmem,
   output logic          e_jal,
   output logic [4:0]    e_rn,
   output logic [31:0]   e_pc4,
   output logic [31:0]   e_db,
   output logic [15:0]   bubble_cnt
);

   ex_regs_t    ex_q, ex_d;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] fwd_a, fwd_b;
   logic        load_use;
   logic        bubble;

   fwd_mux u_fwd_rs (
      .src_i        (d_rs),
      .rf_data_i    (d_qa),
      .ex_valid_i   (ex_q.valid),
      .ex_wreg_i    (ex_q.wreg),
      .ex_m2reg_i   (ex_q.m2reg),
      .ex_rn_i      (ex_q.rn),
      .ex_result_i  (e_r),
      .mem_wreg_i   (m_wreg),
      .mem_rn_i     (m_rn),
      .mem_result_i (m_data),
      .data_o       (fwd_a)
   );

   fwd_mux u_fwd_rt (
      .src_i        (d_rt),
      .rf_data_i    (d_qb),
      .ex_valid_i   (ex_q.valid),
      .ex_wreg_i    (ex_q.wreg),
      .ex_m2reg_i   (ex_q.m2reg),
      .ex_rn_i      (ex_q.rn),
      .ex_result_i  (e_r),
      .mem_wreg_i   (m_wreg),
      .mem_rn_i     (m_rn),
      .mem_result_i (m_data),
      .data_o       (fwd_b)
   );

   // A load in EX whose destination is read by decode: its data only exists
   // once the load reaches MEM, so decode waits one cycle.
   assign load_use = d_valid & ex_q.valid & ex_q.m2reg & ex_q.wreg & (ex_q.rn != '0) &
                     ((d_use_rs & (d_rs == ex_q.rn)) | (d_use_rt & (d_rt == ex_q.rn)));

   // A flush kills the decode instruction anyway, so there is nothing to hold.
   assign stall  = load_use & ~flush;
   assign bubble = flush | load_use | ~d_valid;

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid  = 1'b1;
         ex_d.wreg   = d_wreg;
         ex_d.m2reg  = d_m2reg;
         ex_d.wmem   = d_wmem;
         ex_d.jal    = d_jal;
         ex_d.shift  = d_shift;
         ex_d.aluimm = d_aluimm;
         ex_d.aluc   = d_aluc;
         ex_d.rn     = d_rn;
         ex_d.sa     = d_sa;
         ex_d.pc4    = d_pc4;
         ex_d.imm    = d_imm;
         ex_d.qa     = fwd_a;
         ex_d.qb     = fwd_b;
      end
   end

   // Idle slots (~d_valid) are not hazards and are not counted.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (flush | load_use) bubble_cnt_d = sat_inc16(bubble_cnt_q);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ex_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign alu_a      = ex_q.shift  ? {27'b0, ex_q.sa} : ex_q.qa;
   assign alu_b      = ex_q.aluimm ? ex_q.imm         : ex_q.qb;
   assign aluc       = ex_q.aluc;
   assign e_valid    = ex_q.valid;
   assign e_wreg     = ex_q.wreg;
   assign e_m2reg    = ex_q.m2reg;
   assign e_wmem     = ex_q.wmem;
   assign e_jal      = ex_q.jal;
   assign e_rn       = ex_q.rn;
   assign e_pc4      = ex_q.pc4;
   assign e_db       = ex_q.qb;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed-vector bench for id_ex_stage with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
   import pipe_pkg::*;

   logic        clock;
   logic        resetn;
   logic        d_valid;
   logic [4:0]  d_rs, d_rt;
   logic        d_use_rs, d_use_rt;
   logic [31:0] d_qa, d_qb, d_imm, d_pc4;
   logic [4:0]  d_sa, d_rn;
   logic        d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal;
   logic [3:0]  d_aluc;
   logic [31:0] e_r;
   logic [4:0]  m_rn;
   logic        m_wreg;
   logic [31:0] m_data;
   logic        flush;
   logic        stall;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  aluc;
   logic        e_valid, e_wreg, e_m2reg, e_wmem, e_jal;
   logic [4:0]  e_rn;
   logic [31:0] e_pc4, e_db;
   logic [15:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage dut (
      .clock(clock), .resetn(resetn), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_sa(d_sa), .d_pc4(d_pc4),
      .d_rn(d_rn), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
      .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal), .d_aluc(d_aluc),
      .e_r(e_r), .m_rn(m_rn), .m_wreg(m_wreg), .m_data(m_data), .flush(flush),
      .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc),
      .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
      .e_jal(e_jal), .e_rn(e_rn), .e_pc4(e_pc4), .e_db(e_db),
      .bubble_cnt(bubble_cnt)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic clear_inputs();
      d_valid = 0; d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0;
      d_qa = 0; d_qb = 0; d_imm = 0; d_sa = 0; d_pc4 = 0; d_rn = 0;
      d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluimm = 0; d_shift = 0; d_jal = 0;
      d_aluc = ALU_ADD; e_r = 0; m_rn = 0; m_wreg = 0; m_data = 0; flush = 0;
   endtask

   task automatic drive_alu(input logic [4:0] rs, input logic [31:0] qa,
                            input logic [4:0] rt, input logic [31:0] qb,
                            input logic [4:0] rn, input logic [3:0] op,
                            input logic [31:0] pc4);
      d_valid = 1; d_rs = rs; d_qa = qa; d_use_rs = 1; d_rt = rt; d_qb = qb; d_use_rt = 1;
      d_rn = rn; d_wreg = 1; d_m2reg = 0; d_wmem = 0; d_aluimm = 0; d_shift = 0;
      d_jal = 0; d_aluc = op; d_pc4 = pc4; d_imm = 0; d_sa = 0;
   endtask

   task automatic drive_load(input logic [4:0] rn, input logic [31:0] imm);
      d_valid = 1; d_rs = 0; d_qa = 32'h100; d_use_rs = 1; d_rt = rn; d_qb = 0; d_use_rt = 0;
      d_rn = rn; d_wreg = 1; d_m2reg = 1; d_wmem = 0; d_aluimm = 1; d_shift = 0;
      d_jal = 0; d_aluc = ALU_ADD; d_imm = imm; d_sa = 0;
   endtask

   // advance one edge, then sample away from it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      clear_inputs();
      resetn = 0;
      #12;
      check("rst_e_valid", {31'b0, e_valid}, 32'h0);
      check("rst_alu_a", alu_a, 32'h0);
      check("rst_alu_b", alu_b, 32'h0);
      check("rst_aluc", {28'b0, aluc}, 32'h0);
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_bubble_cnt", {16'b0, bubble_cnt}, 32'h0);
      @(negedge clock);
      resetn = 1;
      step();

      // EX forwarding: add $3 then sub reading $3
      drive_alu(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, ALU_ADD, 32'h104);
      step();
      check("add_e_valid", {31'b0, e_valid}, 32'h1);
      check("add_e_rn", {27'b0, e_rn}, 32'h3);
      check("add_alu_a", alu_a, 32'h1);
      check("add_alu_b", alu_b, 32'h2);
      check("add_e_pc4", e_pc4, 32'h104);
      e_r = 32'h10;
      drive_alu(5'd3, 32'h5, 5'd2, 32'h2, 5'd4, ALU_SUB, 32'h108);
      step();
      check("exfwd_alu_a", alu_a, 32'h10);
      check("exfwd_aluc", {28'b0, aluc}, {28'b0, ALU_SUB});

      // Priority: EX ($4=AA) beats MEM ($4=BB)
      e_r = 32'hAA; m_wreg = 1; m_rn = 5'd4; m_data = 32'hBB;
      drive_alu(5'd0, 32'h11, 5'd4, 32'hCC, 5'd0, ALU_ADD, 32'h10C);
      step();
      check("prio_alu_b", alu_b, 32'hAA);
      check("prio_rs0_alu_a", alu_a, 32'h11);

      // Register 0 never forwarded even though EX and MEM both write $0
      e_r = 32'hAA; m_wreg = 1; m_rn = 5'd0; m_data = 32'hBB;
      drive_alu(5'd0, 32'h0, 5'd0, 32'h77, 5'd1, ALU_OR, 32'h110);
      step();
      check("r0_alu_b", alu_b, 32'h77);
      check("r0_e_db", e_db, 32'h77);

      // Load-use: lw $5 then sub reading $5
      m_wreg = 0; m_rn = 0; m_data = 0;
      drive_load(5'd5, 32'h8);
      step();
      check("lw_alu_b", alu_b, 32'h8);
      check("lw_e_m2reg", {31'b0, e_m2reg}, 32'h1);
      e_r = 32'h108;
      drive_alu(5'd5, 32'h99, 5'd0, 32'h0, 5'd6, ALU_SUB, 32'h118);
      #1;
      check("lu_stall", {31'b0, stall}, 32'h1);
      step();
      check("lu_bubble_valid", {31'b0, e_valid}, 32'h0);
      check("lu_bubble_wreg", {31'b0, e_wreg}, 32'h0);
      check("lu_bubble_alu_a", alu_a, 32'h0);
      check("lu_bubble_cnt", {16'b0, bubble_cnt}, 32'h1);
      check("lu_stall_released", {31'b0, stall}, 32'h0);
      m_wreg = 1; m_rn = 5'd5; m_data = 32'h5A5A;
      step();
      check("lu_enter_valid", {31'b0, e_valid}, 32'h1);
      check("lu_mem_fwd_alu_a", alu_a, 32'h5A5A);
      check("lu_enter_rn", {27'b0, e_rn}, 32'h6);

      // Flush together with load-use
      m_wreg = 0; m_rn = 0; m_data = 0;
      drive_load(5'd7, 32'h4);
      step();
      drive_alu(5'd7, 32'h1, 5'd0, 32'h0, 5'd2, ALU_ADD, 32'h120);
      flush = 1;
      #1;
      check("flush_stall", {31'b0, stall}, 32'h0);
      step();
      flush = 0;
      check("flush_e_valid", {31'b0, e_valid}, 32'h0);
      check("flush_bubble_cnt", {16'b0, bubble_cnt}, 32'h2);

      // Shift with immediate; rt forwarded from MEM into store data
      drive_alu(5'd0, 32'h0, 5'd9, 32'hDEAD, 5'd8, ALU_SLL, 32'h124);
      d_shift = 1; d_sa = 5'd7; d_aluimm = 1; d_imm = 32'h1234;
      m_wreg = 1; m_rn = 5'd9; m_data = 32'hBEEF;
      step();
      check("sh_alu_a", alu_a, 32'h7);
      check("sh_alu_b", alu_b, 32'h1234);
      check("sh_e_db", e_db, 32'hBEEF);
      check("sh_aluc", {28'b0, aluc}, {28'b0, ALU_SLL});

      // Idle decode slot: bubble but not counted
      clear_inputs();
      step();
      check("idle_e_valid", {31'b0, e_valid}, 32'h0);
      check("idle_bubble_cnt", {16'b0, bubble_cnt}, 32'h2);

      // Asynchronous reset mid-run
      drive_alu(5'd1, 32'h33, 5'd2, 32'h44, 5'd3, ALU_ADD, 32'h200);
      step();
      check("pre_rst_e_valid", {31'b0, e_valid}, 32'h1);
      #2 resetn = 0;
      #1;
      check("midrst_e_valid", {31'b0, e_valid}, 32'h0);
      check("midrst_alu_a", alu_a, 32'h0);
      check("midrst_bubble_cnt", {16'b0, bubble_cnt}, 32'h0);
      check("midrst_stall", {31'b0, stall}, 32'h0);
      d_valid = 0;
      @(negedge clock);
      resetn = 1;
      step();
      check("post_rst_empty", {31'b0, e_valid}, 32'h0);
      drive_alu(5'd1, 32'h33, 5'd2, 32'h44, 5'd3, ALU_ADD, 32'h200);
      step();
      check("post_rst_e_valid", {31'b0, e_valid}, 32'h1);
      check("post_rst_alu_a", alu_a, 32'h33);

      // report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, register numbers 5 bits.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 d_valid  in  1  decode stage holds a valid instruction.
REQ-005 d_rs, d_rt  in  5 each  source register numbers; d_use_rs, d_use_rt  in  1 each  source actually read.
REQ-006 d_qa, d_qb  in  32 each  register-file read data for rs, rt.
REQ-007 d_imm  in  32  extended immediate; d_sa  in  5  shift amount; d_pc4  in  32  PC+4.
REQ-008 d_rn  in  5  destination; d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal  in  1 each  decoded controls; d_aluc  in  4  ALU op.
REQ-009 e_r  in  32  ALU result of the instruction currently in EX (fed back from the ALU).
REQ-010 m_rn  in  5; m_wreg  in  1; m_data  in  32  MEM-stage destination, write enable, final result.
REQ-011 flush  in  1  kill the instruction in decode (taken branch/jump).
REQ-012 stall  out  1  hold PC and IF/ID this cycle (combinational).
REQ-013 alu_a, alu_b  out  32 each; aluc  out  4  operands and op for the ALU.
REQ-014 e_valid, e_wreg, e_m2reg, e_wmem, e_jal  out  1 each; e_rn  out  5; e_pc4, e_db  out  32 (e_db = store data).
REQ-015 bubble_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-016 Forwarding per source (rs, rt) SHALL select, in priority: EX (e_valid & e_wreg & ~e_m2reg & e_rn==src & src!=0 -> e_r), then MEM (m_wreg & m_rn==src & src!=0 -> m_data), else d_qa/d_qb.
REQ-017 Register 0 SHALL never be forwarded; source 0 always takes register-file data.
REQ-018 load_use = d_valid & e_valid & e_m2reg & e_wreg & e_rn!=0 & ((d_use_rs & d_rs==e_rn) | (d_use_rt & d_rt==e_rn)).
REQ-019 stall SHALL equal load_use & ~flush.
REQ-020 Each rising edge: if flush or load_use or ~d_valid, EX registers load a bubble (e_valid=0, e_wreg=0, e_wmem=0, e_m2reg=0, e_jal=0, others don't-care but SHALL be 0); else load forwarded operands and all d_* fields.
REQ-021 Flush SHALL take precedence over load_use; both together produce one bubble and stall=0.
REQ-022 alu_a SHALL be {27'b0, e_sa} when e_shift, else registered rs operand; alu_b SHALL be e_imm when e_aluimm, else registered rt operand; aluc = registered aluc; all combinational from EX registers (zero added latency).
REQ-023 e_db SHALL be the registered forwarded rt operand regardless of e_aluimm.
REQ-024 Decode-to-EX latency: exactly one cycle; a stalled instruction enters EX on the cycle after the load leaves EX (one bubble per load-use).
REQ-025 bubble_cnt SHALL increment on each edge where a bubble is loaded due to load_use or flush (not ~d_valid), saturating at 16'hFFFF.

Reset
REQ-026 resetn low SHALL asynchronously clear all EX registers and bubble_cnt to 0; outputs then read e_valid=0, alu_a=0, alu_b=0, aluc=0, stall=0.
REQ-027 Reset deassertion mid-stream SHALL leave EX empty; first valid decode instruction enters EX on the next edge.

Structure
REQ-028 ALU op encodings (ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111) SHALL live in the shared package pipe_pkg.
REQ-029 Forwarding select SHALL be one sub-module fwd_mux, instantiated for rs and rt.

Verification
REQ-030 Reset: resetn=0 mid-run with e_valid=1 -> immediately e_valid=0, alu_a=0, bubble_cnt=0.
REQ-031 EX forward: add $3 (e_r=32'h10) then sub using rs=3, d_qa=32'h5 -> next cycle alu_a=32'h10.
REQ-032 Priority: EX writes $4=32'hAA, MEM writes $4=32'hBB, decode reads rt=4 -> alu_b=32'hAA; with rt=0 and both writing $0 -> alu_b=d_qb.
REQ-033 Load-use: lw $5 in EX, decode uses rs=5 -> stall=1 one cycle, one bubble, bubble_cnt +1, then instruction enters EX with MEM-forwarded m_data.
REQ-034 Flush with load_use together -> stall=0, one bubble, bubble_cnt +1.
REQ-035 Shift/immediate: d_shift=1, d_sa=5'd7, d_aluimm=1, d_imm=32'h1234 -> alu_a=32'h7, alu_b=32'h1234, e_db=forwarded rt.
